decoder_scan: RTL and testbench
===============================

# decoder_scan

Parametrised registered N-to-2^N one-hot decoder, the successor to the lab 2-to-4 combinational decoder. Adds an enable, a registered output, and an autonomous scan mode that steps the active output through all 2^N positions at a programmable rate, for digit-select and LED-chaser duties. Sits between control logic (or a free-running top level) and board-level select lines.

## Interface
- SEL_W, default 2: select width; OUT_W = 2**SEL_W outputs (localparam, not overridable).
- SCAN_DIV, default 4: clock cycles per scan step, legal range 1..2^16; prescaler width = clog2(SCAN_DIV), minimum 1 bit.
- sys_clk  in  1  system clock; all state updates on the rising edge.
- sys_rst  in  1  reset, synchronous and active-high.
- en  in  1  decoder enable; 0 forces outputs off and freezes scan state.
- mode  in  1  0 = direct decode of sel, 1 = autonomous scan.
- sel  in  SEL_W  index to decode in direct mode; ignored in scan mode.
- out  out  OUT_W  registered one-hot output; all-zero when off.
- idx  out  SEL_W  registered index of the active bit (binary of out when out != 0).
- wrap  out  1  one-cycle pulse when scan moves from bit OUT_W-1 to bit 0.

## Operation
- Reset: out = 0, idx = 0, wrap = 0, prescaler = 0, state OFF.
- State per cycle, evaluated from the inputs sampled at the same edge: OFF if en = 0, DIRECT if en = 1 and mode = 0, SCAN if en = 1 and mode = 1. No other states exist.
- OFF: out <= 0, wrap <= 0, idx and prescaler hold.
- DIRECT: out <= 1 << sel, idx <= sel, prescaler <= 0, wrap <= 0.
- SCAN, prescaler < SCAN_DIV-1: prescaler += 1, idx holds, out <= 1 << idx, wrap <= 0.
- SCAN, prescaler == SCAN_DIV-1: prescaler <= 0, idx <= (idx+1) mod OUT_W (natural SEL_W wrap), out <= 1 << idx_next, wrap <= (idx == OUT_W-1).
- SCAN_DIV = 1: prescaler is constant 0, so idx steps every cycle.
- DIRECT->SCAN: scan continues from the last direct idx; the prescaler is already 0, so the first step comes SCAN_DIV cycles after entry.
- SCAN->DIRECT: out = onehot(sel) on the next edge, and any prescaler progress is discarded.
- OFF->SCAN: out resumes onehot(idx) on the next edge, and the prescaler resumes from its frozen value.
- out is always 0 or exactly one-hot; never multi-hot.

## Timing
- Latency of 1 cycle from sel/en/mode to out/idx/wrap. No combinational input-to-output path.
- Scan period is SCAN_DIV x OUT_W cycles. wrap is high for exactly 1 cycle per period, aligned with out = 1.
- sys_rst overrides all other inputs at the edge, including in the middle of a scan or at a wrap edge. wrap is never asserted on the cycle after reset.

## Configuration
- DECODER_SCAN_EN defined: full behaviour as above.
- DECODER_SCAN_EN undefined: prescaler and scan logic are not built. mode is ignored and treated as 0, so en = 1 always means DIRECT. wrap is tied to 0. Port list is unchanged.

## Test plan
All scenarios use SEL_W = 2 and SCAN_DIV = 3 unless stated otherwise.
- Reset, then en = 1, mode = 0, sel = 0..3 on consecutive cycles -> out = 0001, 0010, 0100, 1000, each 1 cycle after its sel; idx matches sel.
- en = 1, mode = 1 from idx = 0 -> out holds 0001 for 3 cycles, then 0010, 0100, 1000 for 3 cycles each. wrap = 1 only on the cycle out returns to 0001, which is 12 cycles after the first 0001.
- Mid-scan at idx = 2 with prescaler = 1, drop en for 5 cycles -> out = 0000 throughout, then out = 0100 for 1 more cycle, then 1000.
- Scan at idx = 3, then switch to mode = 0 with sel = 1 -> next out = 0010, wrap = 0. Switch back to mode = 1 -> 0010 held 3 cycles, then 0100.
- Assert sys_rst for 1 cycle at the exact step edge from 1000 to 0001 -> out = 0000, idx = 0, wrap = 0 the following cycle. Scan then restarts at 0001.
- With DECODER_SCAN_EN undefined, mode = 1 and sel = 2 -> out = 0100 and wrap stays 0. Also run SCAN_DIV = 1 with the macro defined -> one-hot step on every cycle.

Source files
------------

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable and an autonomous scan mode.
// Scan logic (prescaler, index stepping, wrap pulse) is built only when DECODER_SCAN_EN is defined.
module decoder_scan #(
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 4,
    localparam int OUT_W   = 2 ** SEL_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_OFF,
        S_DIRECT,
        S_SCAN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] w_idx_next;
    logic             r_wrap;
    logic             w_wrap_next;

`ifdef DECODER_SCAN_EN
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_next;
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_OFF;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
`ifdef DECODER_SCAN_EN
            r_pre   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_wrap  <= w_wrap_next;
`ifdef DECODER_SCAN_EN
            r_pre   <= w_pre_next;
`endif
        end
    end

    always_comb begin
        w_state_next = S_OFF;
        w_idx_next   = r_idx;
        w_wrap_next  = 1'b0;
`ifdef DECODER_SCAN_EN
        w_pre_next   = r_pre;
`endif
        if (en) begin
`ifdef DECODER_SCAN_EN
            if (mode) begin
                w_state_next = S_SCAN;
                if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
                    w_pre_next  = '0;
                    w_idx_next  = r_idx + 1'b1;
                    w_wrap_next = (r_idx == '1);
                end else begin
                    w_pre_next  = r_pre + 1'b1;
                end
            end else begin
                w_state_next = S_DIRECT;
                w_idx_next   = sel;
                w_pre_next   = '0;
            end
`else
            w_state_next = S_DIRECT;
            w_idx_next   = sel;
`endif
        end
    end

    // In every non-OFF state out == onehot(idx), so out is decoded straight from
    // the state and index flops: one-hot by construction, no input-to-output path.
    assign out  = (r_state == S_OFF) ? '0 : (OUT_W'(1) << r_idx);
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: SCAN_DIV=3 and SCAN_DIV=1 instances share one
// stimulus stream; a spec-level model pushes expectations, popped after each edge.
module tb_decoder_scan;

`ifdef DECODER_SCAN_EN
    localparam bit SCAN_BUILT = 1'b1;
`else
    localparam bit SCAN_BUILT = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       en      = 1'b0;
    logic       mode    = 1'b0;
    logic [1:0] sel     = 2'd0;

    logic [3:0] out0, out1;
    logic [1:0] idx0, idx1;
    logic       wrap0, wrap1;

    decoder_scan #(.SEL_W(2), .SCAN_DIV(3)) u_dut3 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .out     (out0),
        .idx     (idx0),
        .wrap    (wrap0)
    );

    decoder_scan #(.SEL_W(2), .SCAN_DIV(1)) u_dut1 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .out     (out1),
        .idx     (idx1),
        .wrap    (wrap1)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] o0;
        logic [1:0] i0;
        logic       w0;
        logic [3:0] o1;
        logic [1:0] i1;
        logic       w1;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   m_idx[2] = '{0, 0};
    int   m_pre[2] = '{0, 0};
    int   divs[2]  = '{3, 1};

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic m, input logic [1:0] s);
        exp_t       x;
        logic [3:0] eo [2];
        logic [1:0] ei [2];
        logic       ew [2];
        sys_rst = r;
        en      = e;
        mode    = m;
        sel     = s;
        for (int k = 0; k < 2; k++) begin
            ew[k] = 1'b0;
            if (r) begin
                m_idx[k] = 0;
                m_pre[k] = 0;
                eo[k]    = 4'b0000;
            end else if (!e) begin
                eo[k] = 4'b0000;
            end else if (SCAN_BUILT && m) begin
                if (m_pre[k] == divs[k] - 1) begin
                    m_pre[k] = 0;
                    ew[k]    = (m_idx[k] == 3);
                    m_idx[k] = (m_idx[k] + 1) % 4;
                end else begin
                    m_pre[k] = m_pre[k] + 1;
                end
                eo[k] = 4'b0001 << m_idx[k];
            end else begin
                m_idx[k] = int'(s);
                m_pre[k] = 0;
                eo[k]    = 4'b0001 << s;
            end
            ei[k] = m_idx[k][1:0];
        end
        x.o0 = eo[0]; x.i0 = ei[0]; x.w0 = ew[0];
        x.o1 = eo[1]; x.i1 = ei[1]; x.w1 = ew[1];
        q.push_back(x);
        @(posedge sys_clk);
        #1;
        if (q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1 entries");
        end else begin
            x = q.pop_front();
            check("out_div3",  out0,          x.o0);
            check("idx_div3",  {2'b00, idx0}, {2'b00, x.i0});
            check("wrap_div3", {3'b000, wrap0}, {3'b000, x.w0});
            check("out_div1",  out1,          x.o1);
            check("idx_div1",  {2'b00, idx1}, {2'b00, x.i1});
            check("wrap_div1", {3'b000, wrap1}, {3'b000, x.w1});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge sys_clk);
        step(1, 0, 0, 2'd0);
        step(1, 1, 1, 2'd3);

        for (int i = 0; i < 4; i++) step(0, 1, 0, 2'(i));

        step(0, 1, 0, 2'd0);
        for (int i = 0; i < 14; i++) step(0, 1, 1, 2'($urandom_range(0, 3)));

        step(0, 1, 0, 2'd2);
        step(0, 1, 1, 2'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 2'($urandom_range(0, 3)));
        for (int i = 0; i < 3; i++) step(0, 1, 1, 2'd1);

        step(0, 1, 0, 2'd3);
        step(0, 1, 1, 2'd2);
        step(0, 1, 0, 2'd1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 2'd3);

        step(0, 1, 0, 2'd3);
        step(0, 1, 1, 2'd0);
        step(0, 1, 1, 2'd0);
        step(1, 1, 1, 2'd2);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 2'd2);

        step(0, 0, 0, 2'd1);
        step(1, 0, 1, 2'd1);
        step(0, 1, 1, 2'd2);

        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
